// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low column at a time, debounced press/release,
// and a four-digit shift register of accepted hex keys.
module keypad_scanner #(
  parameter int TICK_DIV       = 100_000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  ROWS,
  output logic [3:0]  COLS,
  input  logic        CLEAR,
  output logic        KEY_VALID,
  output logic [3:0]  KEY_CODE,
  output logic [15:0] HEX
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_DONE = DW'(DEBOUNCE_TICKS);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_t;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    logic [3:0] drv;
    case (col)
      2'd0:    drv = 4'b1110;
      2'd1:    drv = 4'b1101;
      2'd2:    drv = 4'b1011;
      2'd3:    drv = 4'b0111;
      default: drv = 4'b1110;
    endcase
    return drv;
  endfunction

  logic [3:0]    rows_meta_r;
  logic [3:0]    rows_sync_r;
  logic [TW-1:0] tick_cnt_r;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [1:0]    col_r;
  logic [1:0]    col_nxt_s;
  logic [1:0]    row_r;
  logic [1:0]    row_nxt_s;
  logic [DW-1:0] deb_cnt_r;
  logic [DW-1:0] deb_nxt_s;
  logic [DW-1:0] rel_cnt_r;
  logic [DW-1:0] rel_nxt_s;
  logic          tick_s;
  logic          accept_s;
  logic [3:0]    code_s;

  assign tick_s = (tick_cnt_r == TICK_MAX);
  assign code_s = key_map(row_nxt_s, col_r);

  // Two-flop synchronizer for the asynchronous row lines; idle rows read high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rows_meta_r <= 4'b1111;
      rows_sync_r <= 4'b1111;
    end else begin
      rows_meta_r <= ROWS;
      rows_sync_r <= rows_meta_r;
    end
  end

  // Free-running scan tick divider.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Next-state logic: every decision is taken only on a scan tick.
  always_comb begin
    state_nxt_s = state_r;
    col_nxt_s   = col_r;
    row_nxt_s   = row_r;
    deb_nxt_s   = deb_cnt_r;
    rel_nxt_s   = rel_cnt_r;
    accept_s    = 1'b0;
    if (tick_s) begin
      case (state_r)
        SCAN: begin
          if (rows_sync_r != 4'b1111) begin
            row_nxt_s = lowest_low_row(rows_sync_r);
            deb_nxt_s = DEB_ONE;
            rel_nxt_s = '0;
            if (DEB_DONE == DEB_ONE) begin
              accept_s    = 1'b1;
              state_nxt_s = HOLD;
            end else begin
              state_nxt_s = DEBOUNCE;
            end
          end else begin
            col_nxt_s = col_r + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!rows_sync_r[row_r]) begin
            deb_nxt_s = deb_cnt_r + DEB_ONE;
            if ((deb_cnt_r + DEB_ONE) == DEB_DONE) begin
              accept_s    = 1'b1;
              state_nxt_s = HOLD;
              rel_nxt_s   = '0;
            end else begin
              state_nxt_s = DEBOUNCE;
            end
          end else begin
            // Bounce or glitch: drop it and move past this column.
            state_nxt_s = SCAN;
            col_nxt_s   = col_r + 2'd1;
            deb_nxt_s   = '0;
          end
        end
        HOLD: begin
          if (rows_sync_r == 4'b1111) begin
            if ((rel_cnt_r + DEB_ONE) == DEB_DONE) begin
              state_nxt_s = SCAN;
              col_nxt_s   = col_r + 2'd1;
              rel_nxt_s   = '0;
              deb_nxt_s   = '0;
            end else begin
              rel_nxt_s = rel_cnt_r + DEB_ONE;
            end
          end else begin
            rel_nxt_s = '0;
          end
        end
        default: begin
          state_nxt_s = SCAN;
          col_nxt_s   = 2'd0;
          deb_nxt_s   = '0;
          rel_nxt_s   = '0;
        end
      endcase
    end else begin
      accept_s = 1'b0;
    end
  end

  // Scan state register; COLS is decoded from the next column so it stays registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= SCAN;
      col_r     <= 2'd0;
      row_r     <= 2'd0;
      deb_cnt_r <= '0;
      rel_cnt_r <= '0;
      COLS      <= 4'b1110;
    end else begin
      state_r   <= state_nxt_s;
      col_r     <= col_nxt_s;
      row_r     <= row_nxt_s;
      deb_cnt_r <= deb_nxt_s;
      rel_cnt_r <= rel_nxt_s;
      COLS      <= col_drive(col_nxt_s);
    end
  end

  // Key outputs and digit register; CLEAR overrides only the digit register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      KEY_VALID <= 1'b0;
      KEY_CODE  <= 4'h0;
      HEX       <= 16'h0000;
    end else begin
      KEY_VALID <= accept_s;
      if (accept_s) begin
        KEY_CODE <= code_s;
      end
      if (CLEAR) begin
        HEX <= 16'h0000;
      end else if (accept_s) begin
        HEX <= {HEX[11:0], code_s};
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix model.
module tb_keypad_scanner;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  ROWS;
  logic [3:0]  COLS;
  logic        CLEAR;
  logic        KEY_VALID;
  logic [3:0]  KEY_CODE;
  logic [15:0] HEX;

  logic       key_on;
  logic [1:0] key_row;
  logic [1:0] key_col;

  int n_total = 0;
  int n_pass  = 0;
  int valid_cnt = 0;

  keypad_scanner #(.TICK_DIV(4), .DEBOUNCE_TICKS(2)) dut (
    .CLK(CLK), .RST(RST), .ROWS(ROWS), .COLS(COLS),
    .CLEAR(CLEAR), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE), .HEX(HEX)
  );

  always #5 CLK = ~CLK;

  // Pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    ROWS = 4'b1111;
    if (key_on && !COLS[key_col]) ROWS[key_row] = 1'b0;
  end

  always @(negedge CLK) if (KEY_VALID) valid_cnt <= valid_cnt + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_key(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge CLK);
      if (KEY_VALID) seen = 1'b1;
    end
    check(tag, {15'h0, seen}, 16'h0001);
  endtask

  task automatic wait_cols(input string tag, input logic [3:0] want);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      if (COLS == want) seen = 1'b1;
    end
    if (!seen) check(tag, {12'h0, COLS}, {12'h0, want});
  endtask

  task automatic press_release(input string tag, input logic [1:0] r, input logic [1:0] c,
                               input logic [3:0] exp_code, input logic [15:0] exp_hex);
    key_row = r; key_col = c; key_on = 1'b1;
    wait_key({tag, "_valid"});
    check({tag, "_code"}, {12'h0, KEY_CODE}, {12'h0, exp_code});
    check({tag, "_hex"}, HEX, exp_hex);
    key_on = 1'b0;
    repeat (40) @(posedge CLK);
  endtask

  initial begin
    RST = 1'b1; CLEAR = 1'b0; key_on = 1'b0; key_row = 2'd0; key_col = 2'd0;
    repeat (3) @(negedge CLK);
    check("rst_cols", {12'h0, COLS}, 16'h000E);
    check("rst_hex", HEX, 16'h0000);
    check("rst_valid", {15'h0, KEY_VALID}, 16'h0000);
    check("rst_code", {12'h0, KEY_CODE}, 16'h0000);
    RST = 1'b0;

    // Asynchronous reset mid-cycle once the scan has moved off column 0.
    repeat (6) @(posedge CLK);
    check("scan_moved", {15'h0, (COLS != 4'b1110)}, 16'h0001);
    @(posedge CLK); #3 RST = 1'b1;
    #1;
    check("async_cols", {12'h0, COLS}, 16'h000E);
    check("async_hex", HEX, 16'h0000);
    check("async_valid", {15'h0, KEY_VALID}, 16'h0000);
    @(negedge CLK); RST = 1'b0;

    // Long hold of '6': one pulse, no repeat.
    key_row = 2'd1; key_col = 2'd2; key_on = 1'b1;
    repeat (160) @(posedge CLK);
    check("hold6_pulses", 16'(valid_cnt), 16'd1);
    check("hold6_code", {12'h0, KEY_CODE}, 16'h0006);
    check("hold6_hex", HEX, 16'h0006);
    key_on = 1'b0;
    repeat (40) @(posedge CLK);

    @(negedge CLK) CLEAR = 1'b1;
    @(negedge CLK) CLEAR = 1'b0;
    check("clear_hex", HEX, 16'h0000);

    press_release("k1", 2'd0, 2'd0, 4'h1, 16'h0001);
    press_release("k2", 2'd0, 2'd1, 4'h2, 16'h0012);
    press_release("k3", 2'd0, 2'd2, 4'h3, 16'h0123);
    press_release("kA", 2'd0, 2'd3, 4'hA, 16'h123A);
    press_release("k5", 2'd1, 2'd1, 4'h5, 16'h23A5);
    check("seq_pulses", 16'(valid_cnt), 16'd6);

    // One-tick glitch on row0/col1: debounce entered, then abandoned.
    wait_cols("glitch_col0", 4'b1110);
    key_row = 2'd0; key_col = 2'd1; key_on = 1'b1;
    wait_cols("glitch_col1", 4'b1101);
    repeat (4) @(posedge CLK);
    #1 key_on = 1'b0;
    @(negedge CLK);
    check("glitch_held_col", {12'h0, COLS}, 16'h000D);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("glitch_next_col", {12'h0, COLS}, 16'h000B);
    repeat (40) @(posedge CLK);
    check("glitch_pulses", 16'(valid_cnt), 16'd6);
    check("glitch_hex", HEX, 16'h23A5);

    // CLEAR coincident with acceptance of '9'.
    wait_cols("clr9_col1", 4'b1101);
    key_row = 2'd2; key_col = 2'd2; key_on = 1'b1;
    wait_cols("clr9_col2", 4'b1011);
    repeat (7) @(posedge CLK);
    #1 CLEAR = 1'b1;
    @(posedge CLK);
    #1 CLEAR = 1'b0;
    @(negedge CLK);
    check("clr9_valid", {15'h0, KEY_VALID}, 16'h0001);
    check("clr9_code", {12'h0, KEY_CODE}, 16'h0009);
    check("clr9_hex", HEX, 16'h0000);
    key_on = 1'b0;
    repeat (40) @(posedge CLK);

    // Reset during HOLD with '0' still pressed.
    key_row = 2'd3; key_col = 2'd1; key_on = 1'b1;
    wait_key("k0_valid");
    check("k0_hex", HEX, 16'h0000);
    repeat (8) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    check("hold_rst_cols", {12'h0, COLS}, 16'h000E);
    check("hold_rst_valid", {15'h0, KEY_VALID}, 16'h0000);
    check("hold_rst_hex", HEX, 16'h0000);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    wait_key("k0_again_valid");
    check("k0_again_code", {12'h0, KEY_CODE}, 16'h0000);
    check("k0_again_hex", HEX, 16'h0000);
    key_on = 1'b0;
    repeat (40) @(posedge CLK);
    check("total_pulses", 16'(valid_cnt), 16'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
